// File: rtl/br_resolve_if.sv
`default_nettype none
// ============================================================================
// Module      : br_resolve_if
// Description : Bus bundle for the branch resolver. Carries the fetch-side
//               prediction record channel, the in-order resolution channel
//               and the flush / predictor-update / statistics outputs.
//               master = fetch/execute side, slave = br_resolve.
// Revision    : 1.0 - initial release
// ============================================================================
interface br_resolve_if;
  // Prediction record channel
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic [31:0] pred_target;
  logic        pred_ready;
  // Resolution channel
  logic        res_valid;
  logic        res_is_br;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  // Flush, predictor update and statistics
  logic        flush;
  logic [31:0] redirect_pc;
  logic [32:0] br_bus;
  logic [31:0] delayslot_pc;
  logic [31:0] br_cnt;
  logic [31:0] mis_cnt;

  modport master (
    output pred_valid, pred_pc, pred_target,
    output res_valid, res_is_br, res_pc, res_taken, res_target,
    input  pred_ready, flush, redirect_pc, br_bus, delayslot_pc, br_cnt, mis_cnt
  );

  modport slave (
    input  pred_valid, pred_pc, pred_target,
    input  res_valid, res_is_br, res_pc, res_taken, res_target,
    output pred_ready, flush, redirect_pc, br_bus, delayslot_pc, br_cnt, mis_cnt
  );
endinterface
`default_nettype wire

// File: rtl/br_resolve.sv
`default_nettype none
// ============================================================================
// Module      : br_resolve
// Description : Tracks taken predictions made at fetch in a small FIFO and
//               checks them against branches resolved in program order.
//               A mispredict raises a one-cycle flush with a restart PC,
//               clears the FIFO and blocks both channels for RECOVER_CYCLES.
//               Define BR_STAT_EN to build the saturating branch/mispredict
//               counters; without it br_cnt and mis_cnt read as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module br_resolve #(
  parameter int DEPTH          = 4,  // power of two, 2..16
  parameter int RECOVER_CYCLES = 2   // 1..15
) (
  input  wire logic   clk,
  input  wire logic   resetn,
  br_resolve_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_rcnt;
  logic        r_flush;
  logic [31:0] r_redirect;
  logic        r_br_e;
  logic [31:0] r_br_target;
  logic [31:0] r_ds_pc;

  logic [31:0] r_q_pc  [DEPTH];
  logic [31:0] r_q_tgt [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;

  logic w_run, w_empty, w_full, w_act, w_hit, w_good, w_taken, w_mis;
  logic w_ready, w_push;

  assign w_run   = (r_state == ST_RUN);
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  assign w_act   = bus.res_valid & w_run;
  assign w_hit   = w_act & !w_empty & (r_q_pc[r_rptr[AW-1:0]] == bus.res_pc);
  assign w_good  = bus.res_is_br & bus.res_taken & (r_q_tgt[r_rptr[AW-1:0]] == bus.res_target);
  assign w_taken = w_act & bus.res_is_br & bus.res_taken;
  // A head match decides by target; otherwise any taken branch was unpredicted.
  assign w_mis   = w_hit ? !w_good : w_taken;

  // A pop in the same cycle frees the slot, so a full queue can still accept.
  assign w_ready = w_run & (!w_full | w_hit);
  assign w_push  = bus.pred_valid & w_ready;

  assign bus.pred_ready   = w_ready;
  assign bus.flush        = r_flush;
  assign bus.redirect_pc  = r_redirect;
  assign bus.br_bus       = {r_br_e, r_br_target};
  assign bus.delayslot_pc = r_ds_pc;

  // Queue storage: written on an accepted push unless a mispredict clears it.
  always_ff @(posedge clk) begin
    if (w_push && !w_mis) begin
      r_q_pc[r_wptr[AW-1:0]]  <= bus.pred_pc;
      r_q_tgt[r_wptr[AW-1:0]] <= bus.pred_target;
    end
  end

  // Queue pointers: a mispredict empties the queue and drops a same-cycle push.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (w_mis) begin
      r_rptr <= r_wptr;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_hit)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  // Recovery FSM with registered flush and restart PC.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= ST_RUN;
      r_rcnt     <= '0;
      r_flush    <= 1'b0;
      r_redirect <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mis) begin
            r_state    <= ST_FLUSH;
            r_flush    <= 1'b1;
            r_redirect <= bus.res_taken ? bus.res_target : bus.res_pc + 32'd4;
          end
        end
        ST_FLUSH: begin
          r_state <= ST_RECOVER;
          r_flush <= 1'b0;
          r_rcnt  <= 4'(RECOVER_CYCLES - 1);
        end
        ST_RECOVER: begin
          if (r_rcnt == 4'd0) r_state <= ST_RUN;
          else                r_rcnt  <= r_rcnt - 4'd1;
        end
        default: begin
          r_state <= ST_RUN;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  // Predictor update for every accepted taken branch, one cycle later.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_br_e      <= 1'b0;
      r_br_target <= '0;
      r_ds_pc     <= '0;
    end else begin
      r_br_e <= w_taken;
      if (w_taken) begin
        r_br_target <= bus.res_target;
        r_ds_pc     <= bus.res_pc;
      end
    end
  end

`ifdef BR_STAT_EN
  logic [31:0] r_br_cnt;
  logic [31:0] r_mis_cnt;

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else begin
      if (w_act && bus.res_is_br && (r_br_cnt != 32'hFFFF_FFFF))
        r_br_cnt <= r_br_cnt + 32'd1;
      if (w_mis && (r_mis_cnt != 32'hFFFF_FFFF))
        r_mis_cnt <= r_mis_cnt + 32'd1;
    end
  end

  assign bus.br_cnt  = r_br_cnt;
  assign bus.mis_cnt = r_mis_cnt;
`else
  assign bus.br_cnt  = 32'd0;
  assign bus.mis_cnt = 32'd0;
`endif

endmodule
`default_nettype wire
